// File: rtl/read_ptr_empty_if.sv
// Read-side FIFO pointer bundle: consumer request, write-domain Gray pointer in,
// read address / Gray pointer / status out.
interface read_ptr_empty_if #(
   parameter int unsigned PTR_WIDTH = 4
);
   localparam int unsigned ADDR_W = PTR_WIDTH - 1;

   logic                 read_en;
   logic [PTR_WIDTH-1:0] wr_ptr_gray;
   logic [ADDR_W-1:0]    rd_addr;
   logic [PTR_WIDTH-1:0] rd_ptr_gray;
   logic                 empty;
   logic [PTR_WIDTH-1:0] rd_count;
   logic                 underflow;

   modport master (
      output read_en, wr_ptr_gray,
      input  rd_addr, rd_ptr_gray, empty, rd_count, underflow
   );

   modport slave (
      input  read_en, wr_ptr_gray,
      output rd_addr, rd_ptr_gray, empty, rd_count, underflow
   );
endinterface

// File: rtl/read_ptr_empty.sv
// Async FIFO read-domain pointer logic: binary/Gray read pointer, write-pointer
// synchronizer, registered empty flag, read-side fill level and sticky underflow.
module read_ptr_empty #(
   parameter int unsigned PTR_WIDTH = 4
) (
   input logic              rd_clk,
   input logic              reset,
   read_ptr_empty_if.slave  bus
);
   localparam int unsigned ADDR_W = PTR_WIDTH - 1;

   logic [PTR_WIDTH-1:0] r_rbin;
   logic [PTR_WIDTH-1:0] r_rgray;
   logic [PTR_WIDTH-1:0] r_wq1;
   logic [PTR_WIDTH-1:0] r_wq2;
   logic [PTR_WIDTH-1:0] r_count;
   logic                 r_empty;
   logic                 r_underflow;

   logic                 w_rd_fire;
   logic                 w_rd_blocked;
   logic [PTR_WIDTH-1:0] w_rbnext;
   logic [PTR_WIDTH-1:0] w_rgnext;
   logic [PTR_WIDTH-1:0] w_wbin_s;

   // A read only advances the pointer when the registered flag says data is present.
   assign w_rd_fire    = bus.read_en & ~r_empty;
   assign w_rd_blocked = bus.read_en &  r_empty;
   assign w_rbnext     = r_rbin + PTR_WIDTH'(w_rd_fire);
   assign w_rgnext     = (w_rbnext >> 1) ^ w_rbnext;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_wbin_s = '0;
      for (int i = 0; i < int'(PTR_WIDTH); i++) begin
         w_wbin_s[i] = ^(r_wq2 >> i);
      end
   end

   // Two-flop synchronizer for the write-domain Gray pointer.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         r_wq1 <= '0;
         r_wq2 <= '0;
      end else begin
         r_wq1 <= bus.wr_ptr_gray;
         r_wq2 <= r_wq1;
      end
   end

   // Read pointer, flags and fill level all resolve against the next pointer value.
   always_ff @(posedge rd_clk or posedge reset) begin
      if (reset) begin
         r_rbin      <= '0;
         r_rgray     <= '0;
         r_empty     <= 1'b1;
         r_count     <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_rbin      <= w_rbnext;
         r_rgray     <= w_rgnext;
         r_empty     <= (w_rgnext == r_wq2);
         r_count     <= w_wbin_s - w_rbnext;
         r_underflow <= r_underflow | w_rd_blocked;
      end
   end

   assign bus.rd_addr     = r_rbin[ADDR_W-1:0];
   assign bus.rd_ptr_gray = r_rgray;
   assign bus.empty       = r_empty;
   assign bus.rd_count    = r_count;
   assign bus.underflow   = r_underflow;
endmodule

// File: tb/tb_read_ptr_empty.sv
// Self-checking bench for read_ptr_empty: directed vector table, corner-case
// sequences and a randomized run against an integer FIFO-occupancy model.
module tb_read_ptr_empty;
   localparam int unsigned PW = 4;
   localparam int unsigned MODN = 16;
   localparam int unsigned DEPTH = 8;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   read_ptr_empty_if #(.PTR_WIDTH(PW)) bus ();

   read_ptr_empty #(.PTR_WIDTH(PW)) dut (
      .rd_clk (clk),
      .reset  (reset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pointers as plain integers; the synchronizer is a 2-deep delay of the write count.
   int unsigned m_rd;
   int unsigned m_wr;
   int unsigned m_d1;
   int unsigned m_d2;
   logic        m_empty;
   int unsigned m_count;
   logic        m_uf;
   logic [PW-1:0] prev_gray;
   bit          saw_wrap;
   int unsigned max_count;

   typedef struct {
      logic          re;
      int unsigned   wr;
      logic          e;
      int unsigned   c;
      int unsigned   a;
      int unsigned   g;
      logic          u;
   } vec_t;

   vec_t tbl[13];

   function automatic logic [PW-1:0] to_gray(input int unsigned b);
      logic [PW-1:0] x;
      x = PW'(b % MODN);
      return x ^ (x >> 1);
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rd = 0; m_wr = 0; m_d1 = 0; m_d2 = 0;
      m_empty = 1'b1; m_count = 0; m_uf = 1'b0;
      prev_gray = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.read_en     = 1'b0;
      bus.wr_ptr_gray = '0;
      reset = 1'b1;
      #2;
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_count", 32'(bus.rd_count), 0);
      chk("rst_addr", 32'(bus.rd_addr), 0);
      chk("rst_gray", 32'(bus.rd_ptr_gray), 0);
      chk("rst_underflow", 32'(bus.underflow), 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // One read-clock cycle: drive at negedge, advance the model at posedge, settle.
   task automatic cycle(input logic re, input int unsigned wr);
      int unsigned fire;
      int unsigned nxt;
      @(negedge clk);
      bus.read_en     = re;
      bus.wr_ptr_gray = to_gray(wr);
      m_wr = wr % MODN;
      @(posedge clk);
      fire = (re && !m_empty) ? 1 : 0;
      if (re && m_empty) m_uf = 1'b1;
      nxt = (m_rd + fire) % MODN;
      m_count = (m_d2 + MODN - nxt) % MODN;
      m_empty = (m_count == 0);
      m_rd = nxt;
      m_d2 = m_d1;
      m_d1 = m_wr;
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_addr"}, 32'(bus.rd_addr), m_rd % DEPTH);
      chk({tag, "_gray"}, 32'(bus.rd_ptr_gray), 32'(to_gray(m_rd)));
      chk({tag, "_empty"}, 32'(bus.empty), 32'(m_empty));
      chk({tag, "_count"}, 32'(bus.rd_count), m_count);
      chk({tag, "_underflow"}, 32'(bus.underflow), 32'(m_uf));
      chk({tag, "_gray_step"}, 32'($countones(prev_gray ^ bus.rd_ptr_gray) <= 1), 1);
      if (prev_gray == PW'(8) && bus.rd_ptr_gray == '0) saw_wrap = 1'b1;
      if (32'(bus.rd_count) > max_count) max_count = 32'(bus.rd_count);
      prev_gray = bus.rd_ptr_gray;
   endtask

   task automatic step(input string tag, input logic re, input int unsigned wr);
      cycle(re, wr);
      check_model(tag);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      saw_wrap = 1'b0;
      max_count = 0;
      reset = 1'b1;
      bus.read_en = 1'b0;
      bus.wr_ptr_gray = '0;
      model_reset();

      // re, wr(binary), empty, count, addr, gray, underflow
      tbl[0]  = '{1'b0, 0, 1'b1, 0, 0, 0, 1'b0};
      tbl[1]  = '{1'b0, 1, 1'b1, 0, 0, 0, 1'b0};
      tbl[2]  = '{1'b0, 1, 1'b1, 0, 0, 0, 1'b0};
      tbl[3]  = '{1'b0, 1, 1'b0, 1, 0, 0, 1'b0};
      tbl[4]  = '{1'b0, 3, 1'b0, 1, 0, 0, 1'b0};
      tbl[5]  = '{1'b0, 3, 1'b0, 1, 0, 0, 1'b0};
      tbl[6]  = '{1'b0, 3, 1'b0, 3, 0, 0, 1'b0};
      tbl[7]  = '{1'b1, 3, 1'b0, 2, 1, 1, 1'b0};
      tbl[8]  = '{1'b1, 3, 1'b0, 1, 2, 3, 1'b0};
      tbl[9]  = '{1'b1, 3, 1'b1, 0, 3, 2, 1'b0};
      tbl[10] = '{1'b1, 3, 1'b1, 0, 3, 2, 1'b1};
      tbl[11] = '{1'b1, 3, 1'b1, 0, 3, 2, 1'b1};
      tbl[12] = '{1'b0, 3, 1'b1, 0, 3, 2, 1'b1};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].re, tbl[i].wr);
         chk($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(tbl[i].e));
         chk($sformatf("vec%0d_count", i), 32'(bus.rd_count), tbl[i].c);
         chk($sformatf("vec%0d_addr", i), 32'(bus.rd_addr), tbl[i].a);
         chk($sformatf("vec%0d_gray", i), 32'(bus.rd_ptr_gray), tbl[i].g);
         chk($sformatf("vec%0d_underflow", i), 32'(bus.underflow), 32'(tbl[i].u));
      end

      // Last word read on the same edge the new write pointer reaches the synchronizer output.
      do_reset();
      step("lastrd_a", 1'b0, 1);
      step("lastrd_b", 1'b0, 1);
      step("lastrd_c", 1'b0, 1);
      step("lastrd_d", 1'b0, 2);
      step("lastrd_e", 1'b0, 2);
      step("lastrd_f", 1'b1, 2);
      step("lastrd_g", 1'b1, 2);
      step("lastrd_h", 1'b1, 2);

      // Reset asserted in the middle of a read cycle clears everything asynchronously.
      step("midrst_a", 1'b1, 4);
      step("midrst_b", 1'b1, 4);
      step("midrst_c", 1'b1, 4);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("midrst_empty", 32'(bus.empty), 1);
      chk("midrst_addr", 32'(bus.rd_addr), 0);
      chk("midrst_gray", 32'(bus.rd_ptr_gray), 0);
      chk("midrst_count", 32'(bus.rd_count), 0);
      do_reset();
      step("postrst", 1'b1, 0);

      // Randomized traffic keeping the write side no more than one FIFO depth ahead.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         int unsigned wprob;
         int unsigned nwr;
         logic        re;
         wprob = ((k / 40) % 2 == 0) ? 70 : 30;
         nwr = m_wr;
         if ($urandom_range(99) < wprob && ((m_wr + MODN - m_rd) % MODN) < DEPTH)
            nwr = (m_wr + 1) % MODN;
         re = ($urandom_range(99) < (100 - wprob)) ? 1'b1 : 1'b0;
         step("rand", re, nwr);
      end
      chk("rand_wrap_seen", 32'(saw_wrap), 1);
      chk("rand_count_le_depth", 32'(max_count <= DEPTH), 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/read_ptr_empty.md
READ_PTR_EMPTY -- requirements
Module: read_ptr_empty

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 4, meaning Gray pointer width; it matches the write-side pointer width.
REQ-002 SHALL derive local ADDR_W = PTR_WIDTH-1, the memory address width; FIFO depth is 2^ADDR_W.
REQ-003 SHALL have port rd_clk, input, 1, read-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port read_en, input, 1, read request from the consumer.
REQ-006 SHALL have port wr_ptr_gray, input, PTR_WIDTH, write-domain Gray pointer; it is asynchronous to rd_clk.
REQ-007 SHALL have port rd_addr, output, ADDR_W, registered binary read address to the FIFO memory.
REQ-008 SHALL have port rd_ptr_gray, output, PTR_WIDTH, registered Gray read pointer for the write domain.
REQ-009 SHALL have port empty, output, 1, registered FIFO-empty flag.
REQ-010 SHALL have port rd_count, output, PTR_WIDTH, registered fill level as seen from the read domain.
REQ-011 SHALL have port underflow, output, 1, sticky flag for a read attempted while empty.

Function
REQ-012 SHALL hold internal binary pointer rbin (PTR_WIDTH); rd_addr = rbin[ADDR_W-1:0].
REQ-013 SHALL compute rd_fire = read_en AND NOT empty, using the registered empty.
REQ-014 SHALL compute rbnext = rbin + rd_fire, modulo 2^PTR_WIDTH; all-ones wraps to zero with no error.
REQ-015 SHALL compute rgnext = (rbnext >> 1) XOR rbnext; each edge registers rbin<=rbnext and rd_ptr_gray<=rgnext.
REQ-016 SHALL pass wr_ptr_gray through a two-flop synchronizer, wq1 then wq2; wq2 alone is used downstream.
REQ-017 SHALL register empty <= (rgnext == wq2), so empty asserts in the same edge that consumes the last word.
REQ-018 SHALL deassert empty at the third rd_clk edge after a stable wr_ptr_gray change: wq1 at edge 1, wq2 at edge 2, empty at edge 3.
REQ-019 SHALL convert wq2 to binary wbin_s (XOR prefix from MSB) and register rd_count <= (wbin_s - rbnext) modulo 2^PTR_WIDTH.
REQ-020 SHALL keep rd_count in the range 0..2^ADDR_W, and SHALL make rd_count==0 coincide with empty on every cycle.
REQ-021 SHALL, when read_en=1 and empty=1, leave rbin, rd_addr and rd_ptr_gray unchanged and set underflow<=1.
REQ-022 SHALL clear underflow only by reset.
REQ-023 SHALL apply the REQ-017 compare on each edge when a write arrives (wq2 changes) in the same cycle as a read, so both events resolve together.
REQ-024 SHALL change at most one bit of rd_ptr_gray per rd_clk edge, including on wrap-around.
REQ-025 SHALL never decrement rbin.

Reset
REQ-026 SHALL, while reset=1, asynchronously force rbin, rd_addr, rd_ptr_gray, wq1, wq2, rd_count and underflow to 0, and empty to 1.
REQ-027 SHALL resume normal operation on the first rd_clk edge after reset deasserts; the write domain must also be reset, or the synchronizer refills within two edges.
REQ-028 SHALL, if reset asserts mid-read, discard the in-flight read and hold no residual state.

Verification
REQ-029 Reset then idle, wr_ptr_gray=0 -> empty=1, rd_count=0, rd_addr=0, rd_ptr_gray=0, underflow=0.
REQ-030 wr_ptr_gray 0->1 at t0, read_en=0 -> empty=1 for edges 1-2, empty=0 and rd_count=1 after edge 3.
REQ-031 Write side holds Gray of 3, read_en=1 for 3 edges -> rd_addr 0,1,2 then 3, rd_ptr_gray 1,3,2, empty=1 after the third read, rd_count=0.
REQ-032 empty=1, read_en=1 for 2 edges -> rbin unchanged, underflow=1 and stays 1 until reset.
REQ-033 PTR_WIDTH=4, 16 writes and 16 reads interleaved -> rbin wraps 15->0, rd_ptr_gray 8->0 with one bit changing, rd_addr wraps 7->0, rd_count never exceeds 8.
REQ-034 Write pointer advances on the same edge the last word is read -> empty deasserts or stays low per REQ-017, with no lost or duplicated address.
